aes_block_packer: RTL



---
 rtl/aes_pkg.sv | 21 ++
 rtl/aes_block_packer_if.sv | 25 ++
 rtl/aes_block_packer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES plaintext block packer.
package aes_pkg;

    localparam int AES_BLOCK_BYTES = 16;
    localparam logic [3:0] LAST_IDX = 4'(AES_BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PAD,
        HOLD
    } packer_state_t;

    typedef logic [127:0] aes_block_t;

    // Byte index 0 occupies the MSBs, so index i starts at bit 8*(15-i).
    function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
        return {~idx, 3'b000};
    endfunction

endpackage

// File: rtl/aes_block_packer_if.sv
// Byte-stream input and 128-bit block output of the AES block packer.
interface aes_block_packer_if;
    import aes_pkg::*;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    aes_block_t out_block;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [4:0] out_bytes;
    logic       busy;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_block, out_valid, out_last, out_bytes, busy
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_block, out_valid, out_last, out_bytes, busy
    );
endinterface

// File: rtl/aes_block_packer.sv
// Packs a plaintext byte stream into padded 16-byte AES state blocks.
// Optional PKCS#7 padding is enabled with the AES_PKCS7_PAD_EN macro.
module aes_block_packer
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    aes_block_packer_if.slave bus
);

    packer_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    aes_block_t    block_q, block_d;
    logic          out_last_q, out_last_d;
    logic [4:0]    out_bytes_q, out_bytes_d;
    logic [7:0]    pad_byte;
    logic          accepting;
    logic          in_acc;

`ifdef AES_PKCS7_PAD_EN
    logic [7:0]    pad_val_q, pad_val_d;
    logic          pad_pending_q, pad_pending_d;
    assign pad_byte = pad_val_q;
`else
    assign pad_byte = 8'h00;
`endif

    assign accepting = (state_q == IDLE) || (state_q == FILL);
    assign in_acc    = accepting && bus.in_valid;

    // in_ready is gated by rst_n so it reads 0 while reset is held.
    assign bus.in_ready  = accepting && rst_n;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_block = block_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_bytes = out_bytes_q;
    assign bus.busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        block_d     = block_q;
        out_last_d  = out_last_q;
        out_bytes_d = out_bytes_q;
`ifdef AES_PKCS7_PAD_EN
        pad_val_d     = pad_val_q;
        pad_pending_d = pad_pending_q;
`endif
        unique case (state_q)
            // cnt is always 0 in IDLE, so IDLE and FILL share the write path.
            IDLE, FILL: begin
                if (in_acc) begin
                    block_d[byte_lsb(cnt_q) +: 8] = bus.in_data;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_IDX) begin
                        state_d     = HOLD;
                        out_bytes_d = 5'd16;
`ifdef AES_PKCS7_PAD_EN
                        out_last_d    = 1'b0;
                        pad_pending_d = bus.in_last;
`else
                        out_last_d    = bus.in_last;
`endif
                    end else if (bus.in_last) begin
                        state_d     = PAD;
                        out_bytes_d = {1'b0, cnt_q} + 5'd1;
`ifdef AES_PKCS7_PAD_EN
                        pad_val_d   = 8'd15 - {4'd0, cnt_q};
`endif
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            PAD: begin
                block_d[byte_lsb(cnt_q) +: 8] = pad_byte;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_IDX) begin
                    state_d    = HOLD;
                    out_last_d = 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    block_d     = '0;
                    cnt_d       = '0;
                    out_last_d  = 1'b0;
                    out_bytes_d = '0;
                    state_d     = IDLE;
`ifdef AES_PKCS7_PAD_EN
                    // Message ended on a block boundary: emit a full pad block.
                    if (pad_pending_q) begin
                        state_d       = PAD;
                        pad_val_d     = 8'h10;
                        pad_pending_d = 1'b0;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            block_q     <= '0;
            out_last_q  <= 1'b0;
            out_bytes_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            block_q     <= block_d;
            out_last_q  <= out_last_d;
            out_bytes_q <= out_bytes_d;
        end
    end

`ifdef AES_PKCS7_PAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_val_q     <= '0;
            pad_pending_q <= 1'b0;
        end else begin
            pad_val_q     <= pad_val_d;
            pad_pending_q <= pad_pending_d;
        end
    end
`endif

endmodule
